// File: rtl/race_input_pkg.sv
// Shared types and sizing helpers for the race-game button front end.
package race_input_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HOLD_DELAY  = 2'd1,
    HOLD_REPEAT = 2'd2
  } rep_state_e;

  // Bits needed to hold values 0..v-1, never less than one.
  function automatic int clog2_w(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: two-flop synchroniser, stable-count debounce, edge pulses and
// an optional hold-to-repeat FSM. Every output comes straight from a flop.
module btn_channel
  import race_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic clk50mhz,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_repeat
);

  localparam int CNT_W  = clog2_w(DEBOUNCE_CYCLES + 1);
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W   = clog2_w(RC_MAX);

  logic             r_s1, r_s2, r_level, r_press, r_release;
  logic [CNT_W-1:0] r_cnt;
  logic             w_accept, w_rise, w_fall;

  assign w_accept = (r_s2 != r_level) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign w_rise   = w_accept && !r_level;
  assign w_fall   = w_accept &&  r_level;

  // NOTE: flops are written with non-blocking assignments so every register
  // samples pre-edge values; blocking here would collapse the synchroniser.
  always_ff @(posedge clk50mhz or negedge reset) begin
    if (!reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s1      <= i_raw;
      r_s2      <= r_s1;
      r_press   <= w_rise;
      r_release <= w_fall;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

  generate
    if (REPEAT_EN != 0) begin : g_repeat
      rep_state_e      r_state, w_state_nxt;
      logic [RC_W-1:0] r_rc, w_rc_nxt;
      logic            r_repeat, w_repeat_nxt;

      always_ff @(posedge clk50mhz or negedge reset) begin
        if (!reset) begin
          r_state  <= IDLE;
          r_rc     <= '0;
          r_repeat <= 1'b0;
        end else begin
          r_state  <= w_state_nxt;
          r_rc     <= w_rc_nxt;
          r_repeat <= w_repeat_nxt;
        end
      end

      // NOTE: every signal gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      always_comb begin
        w_state_nxt  = r_state;
        w_rc_nxt     = r_rc + 1'b1;
        w_repeat_nxt = 1'b0;
        if (w_fall) begin
          // Release wins over any repeat due in the same cycle.
          w_state_nxt = IDLE;
          w_rc_nxt    = '0;
        end else begin
          case (r_state)
            IDLE: begin
              w_rc_nxt = '0;
              if (w_rise) begin
                w_state_nxt  = HOLD_DELAY;
                w_repeat_nxt = 1'b1;
              end
            end
            HOLD_DELAY: begin
              if (r_rc == RC_W'(REPEAT_DELAY - 1)) begin
                w_state_nxt  = HOLD_REPEAT;
                w_repeat_nxt = 1'b1;
                w_rc_nxt     = '0;
              end
            end
            HOLD_REPEAT: begin
              if (r_rc == RC_W'(REPEAT_PERIOD - 1)) begin
                w_repeat_nxt = 1'b1;
                w_rc_nxt     = '0;
              end
            end
            default: begin
              w_state_nxt = IDLE;
              w_rc_nxt    = '0;
            end
          endcase
        end
      end

      assign o_repeat = r_repeat;
    end else begin : g_no_repeat
      assign o_repeat = r_press;
    end
  endgenerate

endmodule

// File: rtl/button_conditioner.sv
// Player-input front end: N_BTN independent conditioned button channels
// between the board pins and the game logic.
module button_conditioner #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000
) (
  input  logic             clk50mhz,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk50mhz (clk50mhz),
      .reset    (reset),
      .i_raw    (btn_raw[i]),
      .o_level  (btn_level[i]),
      .o_press  (btn_press[i]),
      .o_release(btn_release[i]),
      .o_repeat (btn_repeat[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: directed scenarios plus random button activity, all
// compared every edge against a window/arithmetic reference model.
module tb_button_conditioner;

  localparam int N   = 2;
  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;

  logic         clk50mhz = 1'b0;
  logic         reset    = 1'b0;
  logic [N-1:0] btn_raw  = '0;
  logic [N-1:0] lvl_a, prs_a, rel_a, rep_a;
  logic [N-1:0] lvl_b, prs_b, rel_b, rep_b;

  int n_checks = 0;
  int n_bad    = 0;
  int t        = 0;

  // Reference model state: recent raw samples, recent synchronised values,
  // debounced level and the edge index of the last press.
  bit samp [N][$];
  bit s2q  [N][$];
  bit m_lvl[N];
  int m_p  [N];

  always #10 clk50mhz = ~clk50mhz;

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut (
    .clk50mhz(clk50mhz), .reset(reset), .btn_raw(btn_raw),
    .btn_level(lvl_a), .btn_press(prs_a), .btn_release(rel_a), .btn_repeat(rep_a)
  );

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) u_dut_norep (
    .clk50mhz(clk50mhz), .reset(reset), .btn_raw(btn_raw),
    .btn_level(lvl_b), .btn_press(prs_b), .btn_release(rel_b), .btn_repeat(rep_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, t, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      samp[c].delete();
      s2q[c].delete();
      samp[c].push_back(1'b0);
      samp[c].push_back(1'b0);
      m_lvl[c] = 1'b0;
      m_p[c]   = 0;
    end
  endtask

  // One rising edge: advance the model with the raw value the DUT samples,
  // then compare every output just after the edge.
  task automatic step();
    logic [N-1:0] e_lvl, e_prs, e_rel, e_rep;
    bit s2, flip;
    int d;
    @(posedge clk50mhz);
    t++;
    for (int c = 0; c < N; c++) begin
      samp[c].push_back(btn_raw[c]);
      s2 = samp[c][samp[c].size() - 3];
      void'(samp[c].pop_front());
      s2q[c].push_back(s2);
      if (s2q[c].size() > DEB) void'(s2q[c].pop_front());
      flip = (s2q[c].size() == DEB);
      foreach (s2q[c][k]) if (s2q[c][k] == m_lvl[c]) flip = 1'b0;
      e_prs[c] = flip && !m_lvl[c];
      e_rel[c] = flip &&  m_lvl[c];
      if (flip) begin
        m_lvl[c] = !m_lvl[c];
        s2q[c].delete();
      end
      if (e_prs[c]) m_p[c] = t;
      e_lvl[c] = m_lvl[c];
      d = t - m_p[c];
      e_rep[c] = m_lvl[c] && (d == 0 || d == RD || (d > RD && (d - RD) % RP == 0));
    end
    #1;
    check("level",       32'(lvl_a), 32'(e_lvl));
    check("press",       32'(prs_a), 32'(e_prs));
    check("release",     32'(rel_a), 32'(e_rel));
    check("repeat",      32'(rep_a), 32'(e_rep));
    check("norep_level", 32'(lvl_b), 32'(e_lvl));
    check("norep_press", 32'(prs_b), 32'(e_prs));
    check("norep_rel",   32'(rel_b), 32'(e_rel));
    check("norep_rep",   32'(rep_b), 32'(e_prs));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, 32'({lvl_a, prs_a, rel_a, rep_a}), 32'd0);
    check({tag, "_b"}, 32'({lvl_b, prs_b, rel_b, rep_b}), 32'd0);
  endtask

  // Assert reset between edges, check outputs clear at once, hold a few
  // edges, then release away from the clock edge.
  task automatic pulse_reset();
    reset = 1'b0;
    #1;
    check_zero("reset_now");
    repeat (3) @(posedge clk50mhz);
    #1;
    check_zero("reset_hold");
    model_reset();
    #4;
    reset = 1'b1;
  endtask

  task automatic random_phase(input int cycles);
    int left[N];
    for (int c = 0; c < N; c++) left[c] = $urandom_range(1, 8);
    for (int i = 0; i < cycles; i++) begin
      for (int c = 0; c < N; c++) begin
        left[c]--;
        if (left[c] <= 0) begin
          btn_raw[c] = ~btn_raw[c];
          left[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DEB + 1)
                                                : $urandom_range(DEB + 2, 45);
        end
      end
      step();
    end
  endtask

  initial begin
    model_reset();
    btn_raw = '0;
    repeat (2) @(posedge clk50mhz);
    #1;
    check_zero("por");
    #4;
    reset = 1'b1;
    run(3);

    // Clean press on ch0, then release.
    btn_raw[0] = 1'b1;
    run(14);
    btn_raw[0] = 1'b0;
    run(10);

    // Bounce pattern on ch0.
    begin
      bit [7:0] pat;
      pat = 8'b1110_1111;
      for (int i = 7; i >= 0; i--) begin
        btn_raw[0] = pat[i];
        step();
      end
      run(8);
      btn_raw[0] = 1'b0;
      run(10);
    end

    // Both channels pressed together; ch0 released while ch1 keeps repeating.
    btn_raw = 2'b11;
    run(15);
    btn_raw[0] = 1'b0;
    run(25);
    btn_raw[1] = 1'b0;
    run(10);

    // Reset mid-repeat with ch1 held, then held through reset release.
    btn_raw[1] = 1'b1;
    run(22);
    pulse_reset();
    run(30);
    btn_raw = '0;
    run(10);

    random_phase(1500);
    pulse_reset();
    random_phase(800);

    btn_raw = '0;
    run(20);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Parametrised player-input front end for the race game. It takes N_BTN raw, asynchronous push-button lines (left, right, and any later additions) and, per channel, synchronises, debounces and edge-detects them. It also generates an optional hold-to-repeat pulse train. It sits between the board pins and the game logic in `Main`, replacing direct use of raw `left`/`right`.

## Interface
- N_BTN, 2: number of independent button channels (≥1)
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles required to accept a new level (20 ms at 50 MHz; ≥1)
- REPEAT_EN, 1: 1 = hold-to-repeat enabled; 0 = `btn_repeat` equals `btn_press`
- REPEAT_DELAY, 25_000_000: cycles from press to first auto-repeat pulse (≥1)
- REPEAT_PERIOD, 5_000_000: cycles between subsequent repeat pulses (≥1)

Ports:
- clk50mhz  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- btn_raw  in  N_BTN  raw button levels, asynchronous, 1 = pressed
- btn_level  out  N_BTN  debounced level
- btn_press  out  N_BTN  one-cycle pulse on debounced 0→1
- btn_release  out  N_BTN  one-cycle pulse on debounced 1→0
- btn_repeat  out  N_BTN  one-cycle pulse on press and on each auto-repeat

## Operation
- Channels are fully independent; there is no cross-channel interaction.
- Synchroniser: two flops (s1, s2) per channel. Reset value 0.
- Debounce: counter `cnt`, width clog2(DEBOUNCE_CYCLES+1).
  - If s2 == btn_level: cnt ← 0.
  - Else if cnt == DEBOUNCE_CYCLES−1: btn_level ← s2, cnt ← 0, and the matching press or release pulse fires in the same cycle.
  - Else: cnt ← cnt+1.
  - Any bounce back to the current level restarts the count.
- Repeat FSM per channel; states IDLE, HOLD_DELAY, HOLD_REPEAT; counter `rc` sized for max(REPEAT_DELAY, REPEAT_PERIOD).
  - IDLE → HOLD_DELAY on press. btn_repeat pulses and rc ← 0.
  - HOLD_DELAY: rc increments. When rc == REPEAT_DELAY−1, btn_repeat pulses, rc ← 0, and the FSM enters HOLD_REPEAT.
  - HOLD_REPEAT: rc increments. When rc == REPEAT_PERIOD−1, btn_repeat pulses and rc ← 0.
  - From any state, release → IDLE and rc ← 0. No repeat pulse fires in the release cycle.
- REPEAT_EN=0: the FSM is not instantiated and btn_repeat = btn_press.
- All outputs are registered; none is combinational from btn_raw.

## Timing
- Reset: all outputs 0, all counters 0, FSM IDLE. A button held through reset deassertion produces a normal press once debounced.
- Press latency: counting the first edge that samples the new raw value as edge 1, btn_level rises and btn_press pulses at edge DEBOUNCE_CYCLES+2.
- Release latency is the same.
- Repeat: with the press pulse at edge P, repeat pulses occur at P, P+REPEAT_DELAY, and P+REPEAT_DELAY+k·REPEAT_PERIOD for k ≥ 1.
- Press, release and repeat pulses are exactly one cycle wide.
- Press and release never assert in the same cycle on one channel.
- Reset mid-debounce or mid-repeat aborts immediately; no pulse is emitted after release of reset unless the input is re-qualified.
- Raw glitches shorter than DEBOUNCE_CYCLES consecutive cycles produce no output change.

## Structure
- Package `race_input_pkg`: repeat FSM state encoding (IDLE=0, HOLD_DELAY=1, HOLD_REPEAT=2) and a clog2 width helper constant/function.
- Sub-module `btn_channel`: synchroniser, debounce and repeat FSM for one button. The top instantiates it N_BTN times in a generate loop and concatenates the outputs.

## Test plan
Use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N_BTN=2 throughout.
- Clean press: hold btn_raw[0]=1 → btn_level[0] and btn_press[0] rise at edge 6; btn_press[0] is high for one cycle; btn_repeat[0] fires simultaneously.
- Bounce rejection: btn_raw[0] toggles 1,1,1,0,1,1,1,1 per cycle → no press until 4 stable s2 cycles after the last 0; only one press pulse.
- Auto-repeat: hold btn_raw[1] for 30 cycles after its press at P → btn_repeat[1] at P, P+10, P+13, P+16, …; release → btn_release[1] after 6 edges, no further repeats.
- REPEAT_EN=0: same hold → btn_repeat equals btn_press, exactly one pulse.
- Independence: press ch0 and ch1 on the same edge → both press pulses in the same cycle; releasing ch0 does not disturb ch1's repeat cadence.
- Async reset: assert reset low mid-HOLD_REPEAT → all outputs 0 immediately; release reset with the button held → fresh press at edge 6 after release.
